// File: rtl/sfq_nott_driver.sv
// Toggle-encoded clocked-NOT driver/checker; out_valid WIDTH*(SETUP_CYC+Q_WIN+GAP_CYC+2)+1 cycles after accept.
// One word in flight: in_ready only in IDLE, in_valid while busy is ignored (no queueing).
module sfq_nott_driver #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int Q_WIN     = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_tgl,
  output logic             clk_tgl,
  input  logic             q_tgl,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             err,
  output logic             busy
);

  localparam int MAX_SQ = (SETUP_CYC > Q_WIN) ? SETUP_CYC : Q_WIN;
  localparam int MAX_C  = (MAX_SQ > GAP_CYC) ? MAX_SQ : GAP_CYC;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, DATA, SETUP, CLOCK, WAIT_Q, GAP, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] dec_q, dec_d;
  logic             acc_q, acc_d;
  logic             hit_q, hit_d;
  logic             idle_err_q, idle_err_d;
  logic             sync1_q, sync2_q, sync3_q;
  logic             a_q, a_d, c_q, c_d;
  logic             rdy_q, rdy_d, ov_q, ov_d, err_q, err_d, busy_q, busy_d;
  logic [WIDTH-1:0] od_q, od_d;
  logic             pulse;

  // Either edge of the synchronized toggle line is one pulse.
  assign pulse = sync2_q ^ sync3_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    word_d     = word_q;
    dec_d      = dec_q;
    acc_d      = acc_q;
    hit_d      = hit_q;
    idle_err_d = idle_err_q;
    a_d        = a_q;
    c_d        = c_q;
    rdy_d      = rdy_q;
    ov_d       = 1'b0;
    od_d       = od_q;
    err_d      = err_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        rdy_d  = 1'b1;
        busy_d = 1'b0;
        if (pulse) idle_err_d = 1'b1;
        if (in_valid && rdy_q) begin
          word_d     = in_data;
          idx_d      = '0;
          dec_d      = '0;
          acc_d      = idle_err_q | pulse;
          idle_err_d = 1'b0;
          rdy_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (word_q[idx_q]) a_d = ~a_q;
        if (pulse) acc_d = 1'b1;
        cnt_d   = CW'(SETUP_CYC - 1);
        state_d = SETUP;
      end
      SETUP: begin
        if (pulse) acc_d = 1'b1;
        if (cnt_q == '0) state_d = CLOCK;
        else             cnt_d = cnt_q - CW'(1);
      end
      CLOCK: begin
        c_d     = ~c_q;
        if (pulse) acc_d = 1'b1;
        hit_d   = 1'b0;
        cnt_d   = CW'(Q_WIN - 1);
        state_d = WAIT_Q;
      end
      WAIT_Q: begin
        if (pulse) begin
          if (hit_q) acc_d = 1'b1;
          hit_d        = 1'b1;
          dec_d[idx_q] = 1'b1;
        end
        if (cnt_q == '0) begin
          cnt_d   = CW'(GAP_CYC - 1);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (pulse) acc_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (idx_q == IW'(WIDTH - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = DATA;
        end
      end
      DONE: begin
        // A stray pulse here belongs to whatever word comes next.
        if (pulse) idle_err_d = 1'b1;
        ov_d    = 1'b1;
        od_d    = dec_q;
        err_d   = acc_q | (dec_q != ~word_q);
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      dec_q      <= '0;
      acc_q      <= 1'b0;
      hit_q      <= 1'b0;
      idle_err_q <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      a_q        <= 1'b0;
      c_q        <= 1'b0;
      rdy_q      <= 1'b0;
      ov_q       <= 1'b0;
      od_q       <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      dec_q      <= dec_d;
      acc_q      <= acc_d;
      hit_q      <= hit_d;
      idle_err_q <= idle_err_d;
      sync1_q    <= q_tgl;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      a_q        <= a_d;
      c_q        <= c_d;
      rdy_q      <= rdy_d;
      ov_q       <= ov_d;
      od_q       <= od_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign a_tgl     = a_q;
  assign clk_tgl   = c_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sfq_nott_driver.sv
// Bench for sfq_nott_driver: vector table, hand sequences and random words against a toggle-level cell model.
module tb_sfq_nott_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       a_tgl, clk_tgl;
  logic       q_tgl = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       err, busy;

  sfq_nott_driver dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .a_tgl(a_tgl), .clk_tgl(clk_tgl), .q_tgl(q_tgl), .out_valid(out_valid),
    .out_data(out_data), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Cell model: a clock pulse with no data pulse since the previous clock
  // produces an output toggle one cycle later; a stuck cell never toggles.
  logic a_prev = 1'b0, c_prev = 1'b0, pend = 1'b0, fire = 1'b0;
  bit   stuck = 1'b0;
  int   a_cnt = 0, c_cnt = 0;
  int   inj_req = 0, inj_done = 0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_prev = 1'b0; c_prev = 1'b0; pend = 1'b0; fire = 1'b0; q_tgl = 1'b0;
      inj_done = inj_req;
    end else begin
      if (fire) q_tgl = ~q_tgl;
      fire = 1'b0;
      if (inj_req != inj_done) begin
        q_tgl = ~q_tgl;
        inj_done = inj_req;
      end
      if (a_tgl != a_prev) begin a_cnt++; pend = 1'b1; end
      if (clk_tgl != c_prev) begin
        c_cnt++;
        if (!pend && !stuck) fire = 1'b1;
        pend = 1'b0;
      end
      a_prev = a_tgl;
      c_prev = clk_tgl;
    end
  end

  task automatic send(input logic [7:0] d, output bit ok);
    int t = 0;
    ok = 1'b0;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    ok = 1'b1;
  endtask

  // Counts edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_out(input int inj_at, input bit junk, input bit b2b, input logic [7:0] bd,
                          output int cyc, output logic [7:0] od, output logic oe);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (junk && cyc == 10) begin in_valid = 1'b1; in_data = 8'h3C; end
      if (junk && cyc == 13) in_valid = 1'b0;
      if (cyc == 50) begin
        chk("ready_low_midword", in_ready, 1'b0);
        chk("busy_midword", busy, 1'b1);
      end
      if (cyc == inj_at) inj_req++;
      if (b2b && cyc == 96) begin in_valid = 1'b1; in_data = bd; end
      if (out_valid) break;
    end
    od = out_data;
    oe = err;
    chk("latency", cyc, 97);
    chk("busy_at_out_valid", busy, 1'b1);
  endtask

  task automatic run_word(input string nm, input int mode, input logic [7:0] din,
                          input logic [7:0] exp_out, input logic exp_err, input int exp_a);
    bit ok;
    int cyc, a0, c0;
    logic [7:0] od;
    logic oe;
    stuck = (mode == 1);
    a0 = a_cnt;
    c0 = c_cnt;
    send(din, ok);
    if (ok) begin
      wait_out((mode == 2) ? 32 : -1, 1'b1, 1'b0, 8'h00, cyc, od, oe);
      chk({nm, "_out_data"}, od, exp_out);
      chk({nm, "_err"}, oe, exp_err);
      chk({nm, "_a_tgl_count"}, a_cnt - a0, exp_a);
      chk({nm, "_clk_tgl_count"}, c_cnt - c0, 8);
      @(posedge clk);
      #1;
      chk({nm, "_strobe_one_cycle"}, out_valid, 1'b0);
      chk({nm, "_busy_drop"}, busy, 1'b0);
      chk({nm, "_ready_back"}, in_ready, 1'b1);
      chk({nm, "_out_hold"}, {out_data, err}, {exp_out, exp_err});
    end
    stuck = 1'b0;
  endtask

  typedef struct {
    string      nm;
    int         mode;   // 0 ideal cell, 1 stuck cell, 2 ideal plus stray pulse in GAP of bit 2
    logic [7:0] din;
    logic [7:0] exp_out;
    logic       exp_err;
    int         exp_a;
  } vec_t;

  initial begin
    vec_t vecs[5];
    bit ok;
    int cyc, ov_seen;
    logic [7:0] od, w;
    logic oe;

    vecs[0] = '{"zero",     0, 8'h00, 8'hFF, 1'b0, 0};
    vecs[1] = '{"a5",       0, 8'hA5, 8'h5A, 1'b0, 4};
    vecs[2] = '{"stuck_0f", 1, 8'h0F, 8'h00, 1'b1, 4};
    vecs[3] = '{"gap_spur", 2, 8'h00, 8'hFF, 1'b1, 0};
    vecs[4] = '{"ones",     0, 8'hFF, 8'h00, 1'b0, 8};

    // Reset state and first-edge ready.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {a_tgl, clk_tgl, out_valid, out_data, err, busy, in_ready}, 14'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_first_edge", in_ready, 1'b1);
    chk("idle_outputs", {a_tgl, clk_tgl, out_valid, out_data, err, busy}, 13'd0);

    for (int i = 0; i < 5; i++)
      run_word(vecs[i].nm, vecs[i].mode, vecs[i].din, vecs[i].exp_out, vecs[i].exp_err, vecs[i].exp_a);

    // Reset during bit 3 of 0x33 aborts the word.
    send(8'h33, ok);
    if (ok) begin
      repeat (40) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {a_tgl, clk_tgl, out_valid, busy, in_ready}, 5'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ov_seen = 0;
      for (int i = 0; i < 120; i++) begin
        @(posedge clk);
        #1;
        if (out_valid) ov_seen++;
      end
      chk("midrst_no_out_valid", ov_seen, 0);
      run_word("after_rst", 0, 8'h01, 8'hFE, 1'b0, 1);
    end

    // Word offered during DONE is taken in the next IDLE cycle.
    send(8'h12, ok);
    if (ok) begin
      wait_out(-1, 1'b0, 1'b1, 8'hC3, cyc, od, oe);
      chk("b2b_first_data", {od, oe}, {8'hED, 1'b0});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("b2b_accepted", {in_ready, busy}, 2'b01);
      wait_out(-1, 1'b0, 1'b0, 8'h00, cyc, od, oe);
      chk("b2b_second_data", {od, oe}, {8'h3C, 1'b0});
    end

    // Random words against the ideal cell: result is the bitwise inverse.
    for (int i = 0; i < 8; i++) begin
      w = 8'($urandom);
      run_word("rand", 0, w, ~w, 1'b0, $countones(w));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
